sseg_capture: RTL and testbench

Receive-side counterpart of the multiplexed 7-segment driver. Samples the time-multiplexed anode and cathode lines, waits until each digit slot is stable, decodes the segment pattern back to a hex nibble and stores it per digit. Used on the observing board and in loop-back self-test to reconstruct the four displayed digits. It also reports malformed patterns and completed frames.

---
 rtl/sseg_capture.sv | 156 +++++++++++++++
 tb/tb_sseg_capture.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_capture.sv
// sseg_capture: receive side of a multiplexed 7-segment display.
// Samples the anode/cathode lines, waits for each digit slot to settle,
// decodes the segment pattern back to a hex nibble and stores it per digit.
// Flags undecodable patterns and multi-anode slots, and pulses when a full
// frame of four valid digits has been seen.
module sseg_capture #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sseg_an,
  input  logic [7:0] sseg_ca,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] dp,
  output logic [3:0] digit_valid,
  output logic       frame_valid,
  output logic       pattern_err
);

  localparam logic [7:0]  SETTLE_MAX  = 8'(SETTLE_CYCLES);
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [11:0] IDLE_WORD   = 12'hFFF;

  // Active-high gfedcba pattern to hex value; bit 4 flags an exact match.
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h3F:   r = {1'b1, 4'h0};
      7'h06:   r = {1'b1, 4'h1};
      7'h5B:   r = {1'b1, 4'h2};
      7'h4F:   r = {1'b1, 4'h3};
      7'h66:   r = {1'b1, 4'h4};
      7'h6D:   r = {1'b1, 4'h5};
      7'h7D:   r = {1'b1, 4'h6};
      7'h07:   r = {1'b1, 4'h7};
      7'h7F:   r = {1'b1, 4'h8};
      7'h6F:   r = {1'b1, 4'h9};
      7'h77:   r = {1'b1, 4'hA};
      7'h7C:   r = {1'b1, 4'hB};
      7'h39:   r = {1'b1, 4'hC};
      7'h5E:   r = {1'b1, 4'hD};
      7'h79:   r = {1'b1, 4'hE};
      7'h71:   r = {1'b1, 4'hF};
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [11:0]     sync1;
  logic [11:0]     sync2;
  logic [11:0]     prev;
  logic [7:0]      stable_cnt;
  logic [3:0]      seen;
  logic [3:0][3:0] digits;

  logic            capture;
  logic [3:0]      cap_an;
  logic [7:0]      cap_ca;
  logic            single;
  logic [1:0]      sel_idx;
  logic            dec_hit;
  logic [3:0]      dec_val;
  logic [3:0]      seen_next;

  // Two-flop synchronizer for all twelve asynchronous display lines.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= IDLE_WORD;
      sync2 <= IDLE_WORD;
    end else begin
      sync1 <= {sseg_an, sseg_ca};
      sync2 <= sync1;
    end
  end

  // Track how long the synchronized word has been unchanged, saturating so
  // that one stable interval yields at most one capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev       <= IDLE_WORD;
      stable_cnt <= 8'd0;
    end else begin
      prev <= sync2;
      if (sync2 != prev) begin
        stable_cnt <= 8'd0;
      end else if (stable_cnt != SETTLE_MAX) begin
        stable_cnt <= stable_cnt + 8'd1;
      end
    end
  end

  assign capture = (stable_cnt == SETTLE_LAST) && (sync2 == prev);
  assign cap_an  = prev[11:8];
  assign cap_ca  = prev[7:0];

  // Classify the anode word and decode the cathode pattern of the slot.
  // NOTE: every signal gets a default first so no path infers a latch.
  always_comb begin
    single  = 1'b0;
    sel_idx = 2'd0;
    case (cap_an)
      4'b1110: begin single = 1'b1; sel_idx = 2'd0; end
      4'b1101: begin single = 1'b1; sel_idx = 2'd1; end
      4'b1011: begin single = 1'b1; sel_idx = 2'd2; end
      4'b0111: begin single = 1'b1; sel_idx = 2'd3; end
      default: begin single = 1'b0; sel_idx = 2'd0; end
    endcase
    {dec_hit, dec_val} = seg_decode(~cap_ca[6:0]);
    seen_next          = seen | (4'b0001 << sel_idx);
  end

  // Update per-digit state and the error / frame pulses on a capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits      <= '0;
      dp          <= 4'd0;
      digit_valid <= 4'd0;
      seen        <= 4'd0;
      frame_valid <= 1'b0;
      pattern_err <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      pattern_err <= 1'b0;
      if (capture && (cap_an != 4'hF)) begin
        if (!single) begin
          pattern_err <= 1'b1;
        end else if (dec_hit) begin
          digits[sel_idx]      <= dec_val;
          dp[sel_idx]          <= ~cap_ca[7];
          digit_valid[sel_idx] <= 1'b1;
          if (seen_next == 4'hF) begin
            frame_valid <= 1'b1;
            seen        <= 4'd0;
          end else begin
            seen <= seen_next;
          end
        end else begin
          pattern_err          <= 1'b1;
          digit_valid[sel_idx] <= 1'b0;
          seen[sel_idx]        <= 1'b0;
        end
      end
    end
  end

  assign digit0 = digits[0];
  assign digit1 = digits[1];
  assign digit2 = digits[2];
  assign digit3 = digits[3];

endmodule

// File: tb/tb_sseg_capture.sv
// Bench for sseg_capture: directed display sequences, a window-based model of
// the expected outputs compared every cycle, plus hand-computed checkpoints.
module tb_sseg_capture;

  localparam int S  = 4;
  localparam int HL = S + 3;

  localparam logic [6:0] SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic [HL*12-1:0] hist;   // hist[j] = input word sampled j+1 edges ago
    logic [3:0][3:0]  dig;
    logic [3:0]       dp;
    logic [3:0]       valid;
    logic [3:0]       seen;
    logic             frame;
    logic             err;
  } model_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sseg_an;
  logic [7:0] sseg_ca;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [3:0] dp, digit_valid;
  logic       frame_valid, pattern_err;

  int vectors    = 0;
  int miscompares = 0;
  int frame_cnt  = 0;
  int err_cnt    = 0;

  model_t m;

  sseg_capture #(.SETTLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sseg_an     (sseg_an),
    .sseg_ca     (sseg_ca),
    .digit0      (digit0),
    .digit1      (digit1),
    .digit2      (digit2),
    .digit3      (digit3),
    .dp          (dp),
    .digit_valid (digit_valid),
    .frame_valid (frame_valid),
    .pattern_err (pattern_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic model_t model_reset();
    model_t r;
    r      = '0;
    r.hist = {HL{12'hFFF}};
    return r;
  endfunction

  // A word is captured once it has been presented for S+1 consecutive edges
  // following a different word; the result appears two edges after that run.
  function automatic model_t step(input model_t cur, input logic [11:0] s);
    model_t      n;
    logic [11:0] w;
    logic        cap;
    logic [3:0]  an;
    logic [6:0]  p;
    int          hits;
    int          idx;
    int          val;
    n       = cur;
    n.frame = 1'b0;
    n.err   = 1'b0;
    w       = cur.hist[12 +: 12];
    cap     = 1'b1;
    for (int j = 1; j <= S + 1; j++)
      if (cur.hist[j*12 +: 12] != w) cap = 1'b0;
    if (cur.hist[(S+2)*12 +: 12] == w) cap = 1'b0;
    an = w[11:8];
    if (cap && an != 4'hF) begin
      hits = 0;
      idx  = 0;
      for (int k = 0; k < 4; k++)
        if (!an[k]) begin hits++; idx = k; end
      if (hits > 1) begin
        n.err = 1'b1;
      end else begin
        p   = ~w[6:0];
        val = -1;
        for (int v = 0; v < 16; v++)
          if (SEG[v] == p) val = v;
        if (val >= 0) begin
          n.dig[idx]   = val[3:0];
          n.dp[idx]    = ~w[7];
          n.valid[idx] = 1'b1;
          n.seen[idx]  = 1'b1;
          if (n.seen == 4'hF) begin
            n.frame = 1'b1;
            n.seen  = 4'h0;
          end
        end else begin
          n.err        = 1'b1;
          n.valid[idx] = 1'b0;
          n.seen[idx]  = 1'b0;
        end
      end
    end
    n.hist = {cur.hist[HL*12-13:0], s};
    return n;
  endfunction

  // Advance the model on every edge the DUT samples its inputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= step(m, {sseg_an, sseg_ca});
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("cycle",
          {6'd0, digit3, digit2, digit1, digit0, dp, digit_valid, frame_valid, pattern_err},
          {6'd0, m.dig[3], m.dig[2], m.dig[1], m.dig[0], m.dp, m.valid, m.frame, m.err});
  end

  // Pulse counters for the hand-computed expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid) frame_cnt <= frame_cnt + 1;
      if (pattern_err) err_cnt   <= err_cnt + 1;
    end
  end

  task automatic apply(input logic [3:0] an, input logic [7:0] ca, input int n);
    sseg_an = an;
    sseg_ca = ca;
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] rot_ca [4];
  int e0, f0;

  initial begin
    rst_n   = 1'b0;
    sseg_an = 4'hF;
    sseg_ca = 8'hFF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle display: nothing captured, no pulses.
    apply(4'hF, 8'hFF, 100);
    check("idle_valid", {28'd0, digit_valid}, 32'h0);
    check("idle_digits", {16'd0, digit3, digit2, digit1, digit0}, 32'h0);
    check("idle_pulses", frame_cnt + err_cnt, 32'd0);

    // Single digit 3 on slot 0 appears on the 7th edge.
    sseg_an = 4'b1110;
    sseg_ca = 8'hB0;
    repeat (6) @(posedge clk);
    #1 check("d0_early_valid", {28'd0, digit_valid}, 32'h0);
    @(posedge clk);
    #1 check("d0_value", {28'd0, digit0}, 32'h3);
    check("d0_valid", {28'd0, digit_valid}, 32'h1);
    check("d0_dp", {28'd0, dp}, 32'h0);
    check("model_d0", {28'd0, m.dig[0]}, 32'h3);
    @(negedge clk);
    apply(4'b1110, 8'hB0, 3);
    apply(4'hF, 8'hFF, 10);

    // Two full rotations showing 1, A, d, F.
    rot_ca[0] = 8'hF9; rot_ca[1] = 8'h88; rot_ca[2] = 8'hA1; rot_ca[3] = 8'h8E;
    f0 = frame_cnt;
    for (int i = 0; i < 4; i++) apply(~(4'b0001 << i), rot_ca[i], 8);
    check("frame1_cnt", frame_cnt - f0, 32'd1);
    check("frame1_digits", {16'd0, digit3, digit2, digit1, digit0}, 32'hFDA1);
    check("frame1_valid", {28'd0, digit_valid}, 32'hF);
    rot_ca[1] = 8'h08;
    for (int i = 0; i < 4; i++) apply(~(4'b0001 << i), rot_ca[i], 8);
    check("frame2_cnt", frame_cnt - f0, 32'd2);
    check("frame2_dp", {28'd0, dp}, 32'h2);
    check("model_dp", {28'd0, m.dp}, 32'h2);

    // Blank pattern on digit 2 is undecodable.
    e0 = err_cnt;
    apply(4'b1011, 8'hFF, 10);
    check("blank_err", err_cnt - e0, 32'd1);
    check("blank_valid", {28'd0, digit_valid}, 32'hB);
    check("blank_digit2", {28'd0, digit2}, 32'hD);

    // Two anodes active together.
    e0 = err_cnt;
    apply(4'b1100, 8'hF9, 10);
    check("multi_err", err_cnt - e0, 32'd1);
    check("multi_digits", {16'd0, digit3, digit2, digit1, digit0}, 32'hFDA1);
    check("multi_valid", {28'd0, digit_valid}, 32'hB);

    // Three-cycle glitch between blanks is rejected.
    apply(4'hF, 8'hFF, 10);
    e0 = err_cnt;
    f0 = frame_cnt;
    apply(4'b0111, 8'hF9, 3);
    apply(4'hF, 8'hFF, 10);
    check("glitch_pulses", (err_cnt - e0) + (frame_cnt - f0), 32'd0);
    check("glitch_digit3", {28'd0, digit3}, 32'hF);
    check("glitch_valid", {28'd0, digit_valid}, 32'hB);

    // Asynchronous reset in the middle of a stable interval.
    sseg_an = 4'b1101;
    sseg_ca = 8'hA4;
    repeat (4) @(negedge clk);
    #3 rst_n = 1'b0;
    #1 check("rst_outputs",
             {6'd0, digit3, digit2, digit1, digit0, dp, digit_valid, frame_valid, pattern_err},
             32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("post_rst_early", {28'd0, digit_valid}, 32'h0);
    @(posedge clk);
    #1 check("post_rst_digit1", {28'd0, digit1}, 32'h2);
    check("post_rst_valid", {28'd0, digit_valid}, 32'h2);
    @(negedge clk);
    apply(4'hF, 8'hFF, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
